// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//
// Registered execute-to-memory stage downstream of the 32-bit ALU. Each
// accepted ALU result is either resolved as a branch (BEQ/BNE, using the
// zero flag) or queued in a 2-entry in-order skid FIFO. The FIFO head is
// presented to the memory/writeback stage under valid/ready flow control.
// A saturating counter records accepted signed-overflow events for debug.
//
// Optional feature macro: ALU_RESULT_OVF_TRAP_EN
//   When defined, an accepted signed overflow is queued with regwr cleared
//   and raises a one-cycle ovf_trap pulse. When undefined, the ovf_trap port
//   does not exist and overflowing results write back normally.
//
// Parameters
//   DEPTH      FIFO entries (fixed at 2)
//   OVF_CNT_W  width of the overflow event counter
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready is registered)
//   in_result, in_cout, in_flag, in_zero, in_rd, in_regwr, in_signed,
//   in_beq, in_bne, in_target
//                       ALU result fields and control
//   out_valid/out_ready downstream handshake
//   out_result, out_rd, out_regwr, out_cout
//                       FIFO head fields
//   branch_taken, branch_target
//                       registered one-cycle taken-branch pulse and target
//   ovf_count           saturating count of accepted signed overflows
//   ovf_trap            one-cycle overflow pulse (macro builds only)
// ---------------------------------------------------------------------------
module alu_result_stage #(
  parameter int DEPTH     = 2,
  parameter int OVF_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_result,
  input  logic                 in_cout,
  input  logic                 in_flag,
  input  logic                 in_zero,
  input  logic [4:0]           in_rd,
  input  logic                 in_regwr,
  input  logic                 in_signed,
  input  logic                 in_beq,
  input  logic                 in_bne,
  input  logic [31:0]          in_target,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_result,
  output logic [4:0]           out_rd,
  output logic                 out_regwr,
  output logic                 out_cout,
  output logic                 branch_taken,
  output logic [31:0]          branch_target,
`ifdef ALU_RESULT_OVF_TRAP_EN
  output logic                 ovf_trap,
`endif
  output logic [OVF_CNT_W-1:0] ovf_count
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  // Control state (reset)
  logic [1:0]           cnt_q, cnt_d;
  logic                 wr_ptr_q, rd_ptr_q;
  logic                 in_ready_q, in_ready_d;
  logic                 br_taken_q, br_taken_d;
  logic [31:0]          br_target_q, br_target_d;
  logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
`ifdef ALU_RESULT_OVF_TRAP_EN
  logic                 ovf_trap_q;
`endif

  // Data storage (not reset; qualified by cnt_q on the way out)
  logic [31:0] res_q   [2];
  logic [4:0]  rd_q    [2];
  logic        regwr_q [2];
  logic        cout_q  [2];

  logic accept, is_branch, push, pop, head_vld, ovf_evt, wr_regwr;

  always_comb begin
    accept    = in_valid & in_ready_q;
    is_branch = in_beq | in_bne;
    // Branches resolve here and never occupy a FIFO slot.
    push      = accept & ~is_branch;
    head_vld  = (cnt_q != 2'd0);
    pop       = head_vld & out_ready;

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    // Registered ready from next-state occupancy: a drain from full only
    // reopens the input on the following cycle, and out_ready never reaches
    // in_ready combinationally.
    in_ready_d = (cnt_d < FULL);

    ovf_evt   = accept & in_signed & in_flag;
    ovf_cnt_d = (ovf_evt && (ovf_cnt_q != {OVF_CNT_W{1'b1}}))
                ? ovf_cnt_q + OVF_CNT_W'(1) : ovf_cnt_q;

    br_taken_d  = accept & ((in_beq & in_zero) | (in_bne & ~in_zero));
    br_target_d = br_taken_d ? in_target : 32'd0;

`ifdef ALU_RESULT_OVF_TRAP_EN
    wr_regwr = in_regwr & ~ovf_evt;
`else
    wr_regwr = in_regwr;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      br_taken_q  <= 1'b0;
      br_target_q <= 32'd0;
      ovf_cnt_q   <= '0;
`ifdef ALU_RESULT_OVF_TRAP_EN
      ovf_trap_q  <= 1'b0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
      ovf_cnt_q   <= ovf_cnt_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
`ifdef ALU_RESULT_OVF_TRAP_EN
      ovf_trap_q  <= ovf_evt;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      res_q[wr_ptr_q]   <= in_result;
      rd_q[wr_ptr_q]    <= in_rd;
      regwr_q[wr_ptr_q] <= wr_regwr;
      cout_q[wr_ptr_q]  <= in_cout;
    end
  end

  // Head fields are forced to zero while empty so stale storage never leaks.
  always_comb begin
    out_valid     = head_vld;
    out_result    = head_vld ? res_q[rd_ptr_q]   : 32'd0;
    out_rd        = head_vld ? rd_q[rd_ptr_q]    : 5'd0;
    out_regwr     = head_vld & regwr_q[rd_ptr_q];
    out_cout      = head_vld & cout_q[rd_ptr_q];
    in_ready      = in_ready_q;
    branch_taken  = br_taken_q;
    branch_target = br_target_q;
    ovf_count     = ovf_cnt_q;
`ifdef ALU_RESULT_OVF_TRAP_EN
    ovf_trap      = ovf_trap_q;
`endif
  end

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_cout, in_flag, in_zero, in_regwr, in_signed;
  logic        in_beq, in_bne, out_ready;
  logic [31:0] in_result, in_target;
  logic [4:0]  in_rd;

  logic        in_ready, out_valid, out_regwr, out_cout, branch_taken;
  logic [31:0] out_result, branch_target;
  logic [4:0]  out_rd;
  logic [15:0] ovf_count;

  logic        s_in_ready, s_out_valid, s_out_regwr, s_out_cout, s_branch_taken;
  logic [31:0] s_out_result, s_branch_target;
  logic [4:0]  s_out_rd;
  logic [3:0]  s_ovf_count;
`ifdef ALU_RESULT_OVF_TRAP_EN
  logic        ovf_trap, s_ovf_trap;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] r;
    logic [4:0]  rd;
    logic        regwr;
    logic        cout;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  alu_result_stage #(.DEPTH(2), .OVF_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_cout(in_cout), .in_flag(in_flag),
    .in_zero(in_zero), .in_rd(in_rd), .in_regwr(in_regwr),
    .in_signed(in_signed), .in_beq(in_beq), .in_bne(in_bne),
    .in_target(in_target), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_regwr(out_regwr),
    .out_cout(out_cout), .branch_taken(branch_taken),
    .branch_target(branch_target),
`ifdef ALU_RESULT_OVF_TRAP_EN
    .ovf_trap(ovf_trap),
`endif
    .ovf_count(ovf_count)
  );

  // Narrow-counter instance sharing the stimulus, used to reach saturation.
  alu_result_stage #(.DEPTH(2), .OVF_CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_result(in_result), .in_cout(in_cout), .in_flag(in_flag),
    .in_zero(in_zero), .in_rd(in_rd), .in_regwr(in_regwr),
    .in_signed(in_signed), .in_beq(in_beq), .in_bne(in_bne),
    .in_target(in_target), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_result(s_out_result), .out_rd(s_out_rd), .out_regwr(s_out_regwr),
    .out_cout(s_out_cout), .branch_taken(s_branch_taken),
    .branch_target(s_branch_target),
`ifdef ALU_RESULT_OVF_TRAP_EN
    .ovf_trap(s_ovf_trap),
`endif
    .ovf_count(s_ovf_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] rd,
                       input logic regwr, input logic sgn, input logic flag,
                       input logic cout, input logic zero, input logic beq,
                       input logic bne, input logic [31:0] tgt);
    in_valid  = v;
    in_result = r;
    in_rd     = rd;
    in_regwr  = regwr;
    in_signed = sgn;
    in_flag   = flag;
    in_cout   = cout;
    in_zero   = zero;
    in_beq    = beq;
    in_bne    = bne;
    in_target = tgt;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic push(input logic [31:0] r, input logic [4:0] rd,
                      input logic sgn, input logic flag, input logic cout);
    drive(1'b1, r, rd, 1'b1, sgn, flag, cout, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  // Scoreboard: sampled on the falling edge, when inputs and outputs are
  // settled for the coming rising edge. Drains are checked before new
  // accepts are pushed.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
          exp_t e;
          exp_t o;
          e = sb_q.pop_front();
          o = '{r: out_result, rd: out_rd, regwr: out_regwr, cout: out_cout};
          chk("sb_head", 64'(o), 64'(e));
        end
      end
      if (in_valid && in_ready && !(in_beq || in_bne)) begin
        exp_t n;
        n.r  = in_result;
        n.rd = in_rd;
`ifdef ALU_RESULT_OVF_TRAP_EN
        n.regwr = in_regwr & ~(in_signed & in_flag);
`else
        n.regwr = in_regwr;
`endif
        n.cout = in_cout;
        sb_q.push_back(n);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    out_ready = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_ovf_count", 64'(ovf_count), 64'd0);
    chk("rst_branch", 64'(branch_taken), 64'd0);

    // Fill the FIFO (one entry overflows), then reset mid-operation.
    push(32'h11, 5'd1, 1'b0, 1'b0, 1'b0);
    tick();
    push(32'h22, 5'd2, 1'b1, 1'b1, 1'b1);
    tick();
    idle();
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    chk("full_ovf_count", 64'(ovf_count), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_out_valid", 64'(out_valid), 64'd0);
    chk("rst2_ovf_count", 64'(ovf_count), 64'd0);
    chk("rst2_branch", 64'(branch_taken), 64'd0);
    chk("rst2_in_ready", 64'(in_ready), 64'd1);
    chk("rst2_out_result", 64'(out_result), 64'd0);

    // Back-to-back with downstream ready.
    out_ready = 1'b1;
    push(32'h0000_0005, 5'd3, 1'b0, 1'b0, 1'b1);
    tick();
    chk("b2b_valid0", 64'(out_valid), 64'd1);
    chk("b2b_result0", 64'(out_result), 64'h5);
    chk("b2b_rd0", 64'(out_rd), 64'd3);
    chk("b2b_ready0", 64'(in_ready), 64'd1);
    push(32'hFFFF_FFFF, 5'd4, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    chk("b2b_result1", 64'(out_result), 64'hFFFF_FFFF);
    chk("b2b_rd1", 64'(out_rd), 64'd4);
    chk("b2b_ready1", 64'(in_ready), 64'd1);
    tick();
    chk("b2b_empty", 64'(out_valid), 64'd0);

    // Backpressure: three offered, two held, third waits upstream.
    out_ready = 1'b0;
    push(32'hA1, 5'd5, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_ready1", 64'(in_ready), 64'd1);
    push(32'hA2, 5'd6, 1'b0, 1'b0, 1'b1);
    tick();
    chk("bp_ready2", 64'(in_ready), 64'd0);
    chk("bp_head2", 64'(out_result), 64'hA1);
    push(32'hA3, 5'd7, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_ready3", 64'(in_ready), 64'd0);
    chk("bp_hold3", 64'(out_result), 64'hA1);
    tick();
    chk("bp_hold4", 64'(out_result), 64'hA1);
    chk("bp_rd4", 64'(out_rd), 64'd5);
    out_ready = 1'b1;
    tick();
    chk("bp_rel_head", 64'(out_result), 64'hA2);
    chk("bp_rel_ready", 64'(in_ready), 64'd1);
    tick();
    idle();
    chk("bp_head3", 64'(out_result), 64'hA3);
    tick();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Simultaneous accept and drain at count 1.
    out_ready = 1'b0;
    push(32'hD1, 5'd8, 1'b0, 1'b0, 1'b0);
    tick();
    out_ready = 1'b1;
    push(32'hD2, 5'd9, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    chk("sim_valid", 64'(out_valid), 64'd1);
    chk("sim_head", 64'(out_result), 64'hD2);
    chk("sim_ready", 64'(in_ready), 64'd1);
    tick();
    chk("sim_empty", 64'(out_valid), 64'd0);

    // Branches.
    drive(1'b1, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40);
    tick();
    idle();
    chk("beq_taken", 64'(branch_taken), 64'd1);
    chk("beq_target", 64'(branch_target), 64'h40);
    chk("beq_no_entry", 64'(out_valid), 64'd0);
    tick();
    chk("beq_pulse_end", 64'(branch_taken), 64'd0);
    drive(1'b1, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h80);
    tick();
    idle();
    chk("bne_z1_none", 64'(branch_taken), 64'd0);
    chk("bne_z1_no_entry", 64'(out_valid), 64'd0);
    drive(1'b1, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80);
    tick();
    idle();
    chk("bne_z0_taken", 64'(branch_taken), 64'd1);
    chk("bne_z0_target", 64'(branch_target), 64'h80);
    drive(1'b1, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hC0);
    tick();
    idle();
    chk("beq_z0_none", 64'(branch_taken), 64'd0);

    // Overflow counting.
    for (int i = 0; i < 3; i++) begin
      push(32'h7000_0000 + 32'(i), 5'd10, 1'b1, 1'b1, 1'b0);
      tick();
`ifdef ALU_RESULT_OVF_TRAP_EN
      chk("ovf_trap_pulse", 64'(ovf_trap), 64'd1);
`endif
    end
    push(32'h1234, 5'd11, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    chk("ovf_count3", 64'(ovf_count), 64'd3);
`ifdef ALU_RESULT_OVF_TRAP_EN
    chk("ovf_trap_none", 64'(ovf_trap), 64'd0);
`endif
    for (int i = 0; i < 12; i++) begin
      push(32'h8000_0000 + 32'(i), 5'd12, 1'b1, 1'b1, 1'b1);
      tick();
    end
    idle();
    chk("sat_reach", 64'(s_ovf_count), 64'hF);
    chk("ovf_count15", 64'(ovf_count), 64'd15);
    for (int i = 0; i < 3; i++) begin
      push(32'h9000_0000, 5'd13, 1'b1, 1'b1, 1'b0);
      tick();
    end
    idle();
    chk("sat_hold", 64'(s_ovf_count), 64'hF);
    chk("ovf_count18", 64'(ovf_count), 64'd18);

    tick();
    tick();
    chk("end_empty", 64'(out_valid), 64'd0);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered execute-to-memory stage that sits directly downstream of the 32-bit ALU in the CPU datapath. It accepts one ALU result per handshake: the 32-bit value, carry-out, overflow flag, zero flag and writeback/branch control. It buffers results in a 2-entry in-order skid FIFO, resolves BEQ/BNE from the zero flag and forwards results to the memory/writeback stage under valid/ready flow control. It also keeps a saturating count of signed-overflow events for debug.

## Interface
- `DEPTH`, 2: FIFO entries; fixed at 2, other values unsupported.
- `OVF_CNT_W`, 16: width of the overflow event counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream holds a valid ALU result.
- `in_ready` out 1: stage can accept; equals (count < 2), registered.
- `in_result` in 32: ALU result.
- `in_cout` in 1: ALU carry-out.
- `in_flag` in 1: ALU signed overflow.
- `in_zero` in 1: ALU zero.
- `in_rd` in 5: destination register.
- `in_regwr` in 1: writeback enable.
- `in_signed` in 1: operation is signed add/sub; qualifies `in_flag`.
- `in_beq`, `in_bne` in 1 each: branch type; at most one set.
- `in_target` in 32: branch target address.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: downstream accepts head.
- `out_result` out 32, `out_rd` out 5, `out_regwr` out 1, `out_cout` out 1: head entry fields.
- `branch_taken` out 1: one-cycle pulse.
- `branch_target` out 32: target accompanying `branch_taken`.
- `ovf_count` out OVF_CNT_W: saturating count of accepted signed overflows.
- `ovf_trap` out 1: only with OVF_TRAP_EN.

## Operation
- Accept = `in_valid & in_ready`; drain = `out_valid & out_ready`.
- `count` ranges 0..2; it changes by +1 on accept only, −1 on drain only, and stays unchanged on both.
- FIFO order is strict; write and read pointers are 1 bit each and wrap 1→0.
- Branch resolution on accept: taken = (`in_beq & in_zero`) | (`in_bne & ~in_zero`).
- Branch entries are not written into the FIFO; they consume no entry.
- Upstream guarantees the ALU ran a subtract for branches; this stage does not check the ALU command.
- `ovf_count` increments on accept with `in_signed & in_flag`, saturates at all-ones and never wraps.
- Entries with `in_regwr`=0 and no branch (e.g. stores) are still queued so memory can consume `out_result`.
- Reset mid-operation discards all entries and any pending branch pulse.
- After reset, every output is 0 except `in_ready`, which is 1.

## Timing
- Latency: accept at edge N makes `out_valid` 1 after edge N, i.e. visible in cycle N+1 with data.
- Outputs come directly from FIFO registers; there is no combinational path from `in_*` to `out_*`.
- `in_ready` is registered, computed from next-state count. It never depends combinationally on `out_ready`.
- A full FIFO plus a drain raises `in_ready` only in the following cycle.
- Throughput: one per cycle while downstream is ready.
- While `out_valid & ~out_ready`, `out_*` are held stable.
- `branch_taken`/`branch_target` are registered and pulse for exactly 1 cycle after the accept edge. They are independent of FIFO occupancy.
- Not-taken branches produce no pulse.
- `ovf_count` updates on the accept edge.

## Configuration
- `ALU_RESULT_OVF_TRAP_EN` defined:
  - An accepted entry with `in_signed & in_flag` is queued with `regwr` forced to 0.
  - `ovf_trap` pulses 1 cycle after the accept edge; the same timing as `branch_taken`.
- `ALU_RESULT_OVF_TRAP_EN` undefined:
  - The `ovf_trap` port is absent.
  - Overflowing results write back normally; only `ovf_count` records them.

## Test plan
- Reset check: assert `reset` 1 cycle with FIFO holding 2 entries. Expect `out_valid`=0, `ovf_count`=0, `branch_taken`=0 and `in_ready`=1 next cycle.
- Back-to-back: push `result`=0x00000005, `rd`=3, then 0xFFFFFFFF, `rd`=4, with `out_ready`=1. Expect them on consecutive cycles starting at N+1, in order, `in_ready` constant 1.
- Backpressure: hold `out_ready`=0 and push 3 values. Expect `in_ready`=0 after the 2nd accept, the 3rd held upstream, and `out_result` stable at the 1st value. Release: order is preserved.
- Branch: BEQ with `in_zero`=1, `in_target`=0x00000040. Expect a 1-cycle `branch_taken` pulse, target 0x40, no FIFO entry. BNE with `zero`=1 gives no pulse.
- Overflow: `in_signed`=1, `in_flag`=1 for 3 accepts. Expect `ovf_count`=3. Preload to 0xFFFF, overflow once: it stays 0xFFFF. With the trap macro: `out_regwr`=0 and an `ovf_trap` pulse.
- Simultaneous: count=1, accept and drain on the same edge. Expect count to stay 1, `in_ready` to stay 1, and the new entry at head next.
